// File: rtl/lsu_ram_master.sv
// Load/store master for the 1-cycle-read-latency data RAM: sub-word stores are read-modify-write, sub-word loads are extended.
// Optional LSU_MISALIGN_ERR_EN: misaligned accesses respond with rsp_err instead of being silently aligned.
module lsu_ram_master #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          ram_wen,
  output logic [AW-1:0] ram_w_addr,
  output logic [DW-1:0] ram_w_data,
  output logic          ram_ren,
  output logic [AW-1:0] ram_r_addr,
  input  logic [DW-1:0] ram_r_data
);

  typedef enum logic [2:0] {
    IDLE,
    LD_RD,
    LD_CAP,
    RMW_RD,
    RMW_WR,
    ST_WR,
`ifdef LSU_MISALIGN_ERR_EN
    ERR,
`endif
    RESP
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          accept;
  logic [AW-1:0] addr_in;
  logic [4:0]    shift;
  logic [DW-1:0] lane_data;
  logic [DW-1:0] load_ext;
  logic [DW-1:0] lane_mask;
  logic [DW-1:0] merged;

  localparam logic [DW-1:0] BYTE_MASK = {{(DW-8){1'b0}}, 8'hFF};
  localparam logic [DW-1:0] HALF_MASK = {{(DW-16){1'b0}}, 16'hFFFF};

  assign accept = req_valid && (state_q == IDLE);

`ifdef LSU_MISALIGN_ERR_EN
  logic err_q, err_d;
  logic misalign;
  assign misalign = (req_size == 2'd1 && req_addr[0]) ||
                    (req_size[1] && (req_addr[1:0] != 2'b00));
  assign addr_in  = req_addr;
  assign rsp_err  = err_q;
`else
  // Without the error path, misaligned addresses are forced to the natural boundary.
  assign addr_in  = (req_size == 2'd0) ? req_addr :
                    (req_size == 2'd1) ? {req_addr[AW-1:1], 1'b0} :
                                         {req_addr[AW-1:2], 2'b00};
  assign rsp_err  = 1'b0;
`endif

  assign shift     = {addr_q[1:0], 3'b000};
  assign lane_data = ram_r_data >> shift;

  always_comb begin
    load_ext = ram_r_data;
    case (size_q)
      2'd0:    load_ext = uns_q ? (lane_data & BYTE_MASK)
                                : {{(DW-8){lane_data[7]}}, lane_data[7:0]};
      2'd1:    load_ext = uns_q ? (lane_data & HALF_MASK)
                                : {{(DW-16){lane_data[15]}}, lane_data[15:0]};
      default: load_ext = ram_r_data;
    endcase
  end

  assign lane_mask = ((size_q == 2'd0) ? BYTE_MASK : HALF_MASK) << shift;
  assign merged    = (ram_r_data & ~lane_mask) | ((wdata_q << shift) & lane_mask);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
`ifdef LSU_MISALIGN_ERR_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = addr_in;
          wdata_d = req_wdata;
          size_d  = req_size;
          uns_d   = req_unsigned;
          rdata_d = '0;
`ifdef LSU_MISALIGN_ERR_EN
          err_d   = 1'b0;
          if (misalign)          state_d = ERR;
          else
`endif
          if (!req_we)           state_d = LD_RD;
          else if (req_size[1])  state_d = ST_WR;
          else                   state_d = RMW_RD;
        end
      end
      LD_RD:  state_d = LD_CAP;
      LD_CAP: begin
        rdata_d = load_ext;
        state_d = RESP;
      end
      RMW_RD: state_d = RMW_WR;
      RMW_WR: state_d = RESP;
      ST_WR:  state_d = RESP;
`ifdef LSU_MISALIGN_ERR_EN
      ERR: begin
        err_d   = 1'b1;
        state_d = RESP;
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
`ifdef LSU_MISALIGN_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
`ifdef LSU_MISALIGN_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_rdata  = rdata_q;
  assign ram_ren    = (state_q == LD_RD) || (state_q == RMW_RD);
  assign ram_wen    = (state_q == RMW_WR) || (state_q == ST_WR);
  assign ram_w_addr = {2'b00, addr_q[AW-1:2]};
  assign ram_r_addr = {2'b00, addr_q[AW-1:2]};
  assign ram_w_data = (state_q == RMW_WR) ? merged : wdata_q;

endmodule

// File: tb/tb_lsu_ram_master.sv
// Directed bench for lsu_ram_master with a behavioural 1-cycle-latency RAM; expectations follow LSU_MISALIGN_ERR_EN.
module tb_lsu_ram_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_wen;
  logic [31:0] ram_w_addr;
  logic [31:0] ram_w_data;
  logic        ram_ren;
  logic [31:0] ram_r_addr;
  logic [31:0] ram_r_data;

  lsu_ram_master #(.AW(32), .DW(32)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .ram_wen      (ram_wen),
    .ram_w_addr   (ram_w_addr),
    .ram_w_data   (ram_w_data),
    .ram_ren      (ram_ren),
    .ram_r_addr   (ram_r_addr),
    .ram_r_data   (ram_r_data)
  );

  always #5 clk = ~clk;

  // RAM model: 1-cycle read latency, new-data on same-address collision.
  logic [31:0] mem [0:63];
  int          wen_total = 0;
  always @(posedge clk) begin
    if (ram_wen) begin
      mem[ram_w_addr[5:0]] <= ram_w_data;
      wen_total <= wen_total + 1;
    end
    if (ram_ren)
      ram_r_data <= (ram_wen && ram_w_addr == ram_r_addr) ? ram_w_data : mem[ram_r_addr[5:0]];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int          lat, wen_at, ren_at;
  logic [31:0] got_rdata, w_addr_seen, r_addr_seen;
  logic        got_err;

  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [1:0] sz, input logic uns);
    int  n;
    logic done;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr;
    req_wdata = wd; req_size = sz; req_unsigned = uns;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    // Garbage on the request bus after accept must not affect the access.
    req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0BAD0BAD;
    req_size = 2'd3; req_unsigned = ~uns; req_we = ~we;
    lat = 0; wen_at = 0; ren_at = 0; done = 1'b0;
    got_rdata = 32'hX; got_err = 1'bX; w_addr_seen = 32'h0; r_addr_seen = 32'h0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (ram_wen && wen_at == 0) begin wen_at = lat; w_addr_seen = ram_w_addr; end
      if (ram_ren && ren_at == 0) begin ren_at = lat; r_addr_seen = ram_r_addr; end
      if (rsp_valid) begin
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
        done      = 1'b1;
      end
    end
  endtask

  task automatic load_chk(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] exp);
    xfer(1'b0, addr, 32'h0, sz, uns);
    check({tag, "_lat"}, lat, 3);
    check({tag, "_data"}, got_rdata, exp);
    check({tag, "_err"}, {31'b0, got_err}, 0);
  endtask

  int ready_cnt, rsp_cnt, wen_snap;

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_size = '0; req_unsigned = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_strobes", {30'b0, ram_wen, ram_ren}, 0);
    check("rst_err", {31'b0, rsp_err}, 0);
    rstn = 1'b1;

    // Word store then word load
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0);
    check("wst_lat", lat, 2);
    check("wst_wen_at", wen_at, 1);
    check("wst_waddr", w_addr_seen, 32'h4);
    check("wst_no_ren", ren_at, 0);
    check("wst_rdata0", got_rdata, 0);
    check("wst_mem", mem[4], 32'hDEADBEEF);
    xfer(1'b0, 32'h10, 32'h0, 2'd2, 1'b1);
    check("wld_lat", lat, 3);
    check("wld_ren_at", ren_at, 1);
    check("wld_raddr", r_addr_seen, 32'h4);
    check("wld_data", got_rdata, 32'hDEADBEEF);

    // Byte store read-modify-write and extended loads
    xfer(1'b1, 32'h10, 32'h11223344, 2'd2, 1'b0);
    xfer(1'b1, 32'h11, 32'hFFFFFFA5, 2'd0, 1'b0);
    check("bst_lat", lat, 3);
    check("bst_ren_at", ren_at, 1);
    check("bst_wen_at", wen_at, 2);
    check("bst_mem", mem[4], 32'h1122A544);
    load_chk("lbs11", 32'h11, 2'd0, 1'b0, 32'hFFFFFFA5);
    load_chk("lbu11", 32'h11, 2'd0, 1'b1, 32'h000000A5);
    load_chk("lbs10", 32'h10, 2'd0, 1'b0, 32'h00000044);

    // Half store and loads
    xfer(1'b1, 32'h10, 32'h11223344, 2'd2, 1'b0);
    xfer(1'b1, 32'h12, 32'h12348001, 2'd1, 1'b0);
    check("hst_lat", lat, 3);
    check("hst_mem", mem[4], 32'h80013344);
    load_chk("lhs12", 32'h12, 2'd1, 1'b0, 32'hFFFF8001);
    load_chk("lhu12", 32'h12, 2'd1, 1'b1, 32'h00008001);
    load_chk("lbs13", 32'h13, 2'd0, 1'b0, 32'hFFFFFF80);

    // Misaligned half load
    xfer(1'b0, 32'h13, 32'h0, 2'd1, 1'b0);
`ifdef LSU_MISALIGN_ERR_EN
    check("mis_lat", lat, 2);
    check("mis_err", {31'b0, got_err}, 1);
    check("mis_rdata", got_rdata, 0);
    check("mis_no_ren", ren_at, 0);
`else
    check("mis_lat", lat, 3);
    check("mis_err", {31'b0, got_err}, 0);
    check("mis_rdata", got_rdata, 32'hFFFF8001);
    check("mis_raddr", r_addr_seen, 32'h4);
`endif

    // req_valid held high: one accept every 4 cycles for loads
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_unsigned = 1'b0;
    ready_cnt = 0; rsp_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) ready_cnt++;
      if (rsp_valid) rsp_cnt++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("stream_accepts", ready_cnt, 5);
    check("stream_rsps", rsp_cnt, 5);

    // Reset during RMW_RD abandons the store
    xfer(1'b1, 32'h10, 32'h11223344, 2'd2, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h11; req_wdata = 32'hA5; req_size = 2'd0;
    @(posedge clk);
    #1;
    check("rmw_rd_ren", {31'b0, ram_ren}, 1);
    wen_snap = wen_total;
    rstn = 1'b0;
    req_valid = 1'b0;
    #1;
    check("rst_async_strobes", {30'b0, ram_wen, ram_ren}, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_no_write", wen_total, wen_snap);
    check("rst_ready_after", {31'b0, req_ready}, 1);
    check("rst_mem", mem[4], 32'h11223344);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
